// File: rtl/cra_pkg.sv
// Shared constants for the registered carry-ripple adder
// and the byte-wide operand-entry controller above it.
package cra_pkg;

   localparam int CRA_WIDTH = 32;
   localparam int CRA_BYTES = CRA_WIDTH / 8;

endpackage

// File: rtl/carry_ripple_adder_full_adder.sv
// Single-bit full-adder cell, purely combinational.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/carry_ripple_adder.sv
// Registered WIDTH-bit ripple adder: {cout,sum} <= a + b + cin on in_valid.
// Ports: clk, rst (sync, active-high), a, b, cin, in_valid -> sum, cout,
// out_valid, and ovf (signed overflow) when CRA_OVERFLOW_EN is defined.
module carry_ripple_adder
   import cra_pkg::*;
#(
   parameter int WIDTH = CRA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef CRA_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             out_valid
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             out_valid_d, out_valid_q;

   assign c[0] = cin;

   // Carry chain: cell i consumes c[i] and produces c[i+1].
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (c[i]),
         .s   (s[i]),
         .cout(c[i+1])
      );
   end

   always_comb begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         sum_d       = s;
         cout_d      = c[WIDTH];
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;

`ifdef CRA_OVERFLOW_EN
   logic ovf_d, ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_comb begin
      ovf_d = ovf_q;
      if (in_valid) begin
         ovf_d = c[WIDTH] ^ c[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_ripple_adder.sv
// Self-checking bench for carry_ripple_adder against an arithmetic model.
// Covers reset, directed boundaries, random, back-to-back, hold, mid reset.
module tb_carry_ripple_adder;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b;
   logic         cin, in_valid;
   logic [W-1:0] sum;
   logic         cout, out_valid;
   logic         ovf_o;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] m_sum;
   logic         m_cout, m_ovf, m_vld;

   always #5 clk = ~clk;

   carry_ripple_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .in_valid (in_valid),
      .sum      (sum),
      .cout     (cout),
`ifdef CRA_OVERFLOW_EN
      .ovf      (ovf_o),
`endif
      .out_valid(out_valid)
   );

`ifndef CRA_OVERFLOW_EN
   assign ovf_o = 1'b0;
`endif

   // Drive one cycle of inputs, advance past the edge, update model.
   task automatic drive(input logic r, input logic [W-1:0] ai,
                        input logic [W-1:0] bi, input logic ci,
                        input logic v);
      logic [W:0] full;
      rst = r; a = ai; b = bi; cin = ci; in_valid = v;
      @(posedge clk);
      #1;
      if (r) begin
         m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
      end else begin
         if (v) begin
            full   = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci};
            m_sum  = full[W-1:0];
            m_cout = full[W];
`ifdef CRA_OVERFLOW_EN
            m_ovf  = (ai[W-1] == bi[W-1]) && (m_sum[W-1] != ai[W-1]);
`endif
         end
         m_vld = v;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++)
         drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      total++;
      if ({sum, cout, out_valid, ovf_o} !== {{W{1'b0}}, 3'b000}) begin
         bad++;
         $display("FAIL reset: got sum=%h cout=%b vld=%b ovf=%b want 0",
                  sum, cout, out_valid, ovf_o);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [6];
      logic [W-1:0] tb [6];
      logic         tc [6];
      ta[0] = 32'h5;        tb[0] = 32'h3;        tc[0] = 1'b0;
      ta[1] = 32'hFFFFFFFF; tb[1] = 32'h0;        tc[1] = 1'b1;
      ta[2] = 32'h7FFFFFFF; tb[2] = 32'h1;        tc[2] = 1'b0;
      ta[3] = 32'hFFFFFFFF; tb[3] = 32'hFFFFFFFF; tc[3] = 1'b1;
      ta[4] = 32'h80000000; tb[4] = 32'h80000000; tc[4] = 1'b0;
      ta[5] = 32'h12345678; tb[5] = ~32'h02345678; tc[5] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, ta[i], tb[i], tc[i], 1'b1);
         total++;
         if ({sum, cout, out_valid} !== {m_sum, m_cout, 1'b1}
             || ovf_o !== m_ovf) begin
            bad++;
            $display("FAIL directed%0d: got %h/%b/%b/%b want %h/%b/1/%b",
                     i, sum, cout, out_valid, ovf_o, m_sum, m_cout, m_ovf);
         end
      end
      // Fixed expectations for the named boundary cases.
      drive(1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
      total++;
      if (sum !== 32'h0 || cout !== 1'b1) begin
         bad++;
         $display("FAIL wrap: got %h/%b want 00000000/1", sum, cout);
      end
      drive(1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1);
      total++;
      if (sum !== 32'h80000000 || cout !== 1'b0) begin
         bad++;
         $display("FAIL maxpos: got %h/%b want 80000000/0", sum, cout);
      end
`ifdef CRA_OVERFLOW_EN
      total++;
      if (ovf_o !== 1'b1) begin
         bad++;
         $display("FAIL ovf: got %b want 1", ovf_o);
      end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'b0, W'($urandom), W'($urandom), 1'($urandom),
               ($urandom_range(3) != 0));
         total++;
         if ({sum, cout, out_valid} !== {m_sum, m_cout, m_vld}
             || ovf_o !== m_ovf) begin
            bad++;
            $display("FAIL random%0d: got %h/%b/%b/%b want %h/%b/%b/%b",
                     i, sum, cout, out_valid, ovf_o,
                     m_sum, m_cout, m_vld, m_ovf);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
         total++;
         if ({sum, cout, out_valid} !== {m_sum, m_cout, 1'b1}
             || ovf_o !== m_ovf) begin
            bad++;
            $display("FAIL b2b%0d: got %h/%b/%b want %h/%b/1",
                     i, sum, cout, out_valid, m_sum, m_cout);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
         total++;
         if ({sum, cout, out_valid} !== {m_sum, m_cout, 1'b0}
             || ovf_o !== m_ovf) begin
            bad++;
            $display("FAIL hold%0d: got %h/%b/%b want %h/%b/0",
                     i, sum, cout, out_valid, m_sum, m_cout);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      total++;
      if ({sum, cout, out_valid, ovf_o} !== {{W{1'b0}}, 3'b000}) begin
         bad++;
         $display("FAIL rst_mid: got %h/%b/%b/%b want 0",
                  sum, cout, out_valid, ovf_o);
      end
      drive(1'b0, 32'h10, 32'h20, 1'b1, 1'b1);
      total++;
      if (sum !== 32'h31 || cout !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL post_rst: got %h/%b/%b want 00000031/0/1",
                  sum, cout, out_valid);
      end
   endtask

   initial begin
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
      rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
